reflet_mem_bridge: RTL
======================

# reflet_mem_bridge

Sits between the CPU's RAM port (address unit output) and a slow or variable-latency memory with a req/ack handshake. The CPU port expects a single-cycle synchronous memory; this block stalls the CPU on misses and writes, runs the handshake, and replays the result. It keeps a one-entry read buffer so repeated reads of the same address cost no extra cycles. A timeout converts a hung access into a bus error.

## Interface
Parameters:
- wordsize, 16, width of address and data buses
- timeout, 255, max cycles waiting for mem_ack; 0 disables the timeout

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- cpu_addr  in  wordsize  address from the CPU
- cpu_data_out  in  wordsize  write data from the CPU
- cpu_write_en  in  1  write request from the CPU
- cpu_data_in  out  wordsize  read data to the CPU
- cpu_stall  out  1  high = CPU must hold; drives the CPU's enable, inverted
- invalidate  in  1  clears the read buffer, for I/O regions
- mem_req  out  1  access request, held until ack or timeout
- mem_we  out  1  write qualifier, stable while mem_req is high
- mem_addr  out  wordsize  registered address, stable while mem_req is high
- mem_wdata  out  wordsize  registered write data
- mem_rdata  in  wordsize  read data, valid when mem_ack is high
- mem_ack  in  1  completes the current request
- bus_error  out  1  one-cycle pulse on timeout

## Operation
- State: buf_valid, buf_addr, buf_data. FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Hit = buf_valid & cpu_addr==buf_addr & !cpu_write_en. On a hit: cpu_stall=0, cpu_data_in=buf_data, stay in IDLE.
  - Miss or write: cpu_stall=1, combinationally in the same cycle. Capture cpu_addr, cpu_data_out and cpu_write_en into mem_addr, mem_wdata and mem_we. Go to BUSY.
- BUSY:
  - mem_req=1 and cpu_stall=1. The wait counter increments each cycle.
  - On mem_ack, read: buf_addr←mem_addr, buf_data←mem_rdata, buf_valid←1.
  - On mem_ack, write: buf_addr←mem_addr, buf_data←mem_wdata, buf_valid←1 (write-through coherence).
  - After mem_ack, go to DONE. mem_req drops in the cycle after ack.
  - Timeout (counter==timeout-1 without ack, timeout≠0): mem_req drops, bus_error pulses, buf_valid←0, buf_data←0. Go to DONE.
- DONE:
  - cpu_stall=0 and cpu_data_in=buf_data. This is the one cycle in which the CPU consumes the result.
  - cpu_write_en and address changes are ignored in this cycle, so a write held during the stall is not re-issued.
  - Next state is IDLE.
- cpu_data_in outside a hit or DONE equals buf_data; its value is don't-care while stalled.
- mem_ack outside BUSY is ignored.
- invalidate:
  - Clears buf_valid at the next edge in any state.
  - If it coincides with an ack in BUSY, the ack's buffer fill still happens and invalidate is applied afterwards, so buf_valid ends at 0.
  - DONE still returns the acked data.
- Address compare uses the full wordsize. No byte-lane logic; byte/alignment handling stays upstream.

## Timing
- Reset (reset low at an edge):
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_error=0.
  - State: FSM=IDLE, buf_valid=0, buf_data=0, counter=0.
  - cpu_stall forced 0 while reset is low.
- Reset mid-BUSY aborts the request: mem_req=0 at the next edge, and no bus_error.
- Read hit: 0 added cycles.
- Miss or write with an ack after N cycles of mem_req (N≥1; ack in the first req cycle is N=1):
  - cycle 0: stall.
  - cycles 1..N: BUSY.
  - cycle N+1: DONE, stall=0.
  - Total CPU hold is N+1 cycles.
- Timeout: bus_error is high in the cycle where BUSY has lasted `timeout` cycles; DONE follows.
- mem_addr, mem_we and mem_wdata change only on the IDLE→BUSY edge.

## Test plan
- Read miss then hit: read 0x0040, ack after 2 req cycles with rdata=0xBEEF.
  - Required: stall for 3 cycles; DONE returns 0xBEEF.
  - A following read of 0x0040 completes with no stall and no mem_req.
- Write then read: write 0x1234 to 0x0010, ack immediately.
  - Required: mem_we=1, mem_wdata=0x1234, a single mem_req transaction.
  - The DONE cycle must not start a second write.
  - The next read of 0x0010 hits and returns 0x1234.
- Timeout: with timeout=4, read 0x0080 and never ack.
  - Required: mem_req high for exactly 4 cycles; bus_error high for 1 cycle; DONE data=0x0000.
  - A re-read of 0x0080 misses.
- Invalidate: buffer holds 0x0040. Pulse invalidate, then read 0x0040 with ack rdata=0x5555.
  - Required: a new mem_req is issued and 0x5555 is returned.
- Reset mid-access: reset low during BUSY.
  - Required: mem_req=0 next cycle, bus_error=0, buf_valid=0.
  - A stray mem_ack afterwards has no effect.
- Back-to-back misses: read 0x0002, then 0x0004, each acked in the first cycle.
  - Required: each access costs exactly 2 stall cycles plus 1 DONE cycle.
  - mem_addr is 0x0002, then 0x0004.

Source files
------------

// File: rtl/reflet_mem_bridge.sv
// Bridges the CPU's single-cycle RAM port to a req/ack memory.
// Keeps a one-entry read buffer and converts hung accesses into a bus error.
module reflet_mem_bridge #(
   parameter int unsigned wordsize = 16,
   parameter int unsigned timeout  = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [wordsize-1:0] cpu_addr,
   input  logic [wordsize-1:0] cpu_data_out,
   input  logic                cpu_write_en,
   output logic [wordsize-1:0] cpu_data_in,
   output logic                cpu_stall,
   input  logic                invalidate,
   output logic                mem_req,
   output logic                mem_we,
   output logic [wordsize-1:0] mem_addr,
   output logic [wordsize-1:0] mem_wdata,
   input  logic [wordsize-1:0] mem_rdata,
   input  logic                mem_ack,
   output logic                bus_error
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int unsigned CW = (timeout < 2) ? 1 : $clog2(timeout + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'((timeout == 0) ? 0 : timeout - 1);

   logic [1:0]          state;
   logic [CW-1:0]       counter;
   logic                buf_valid;
   logic [wordsize-1:0] buf_addr;
   logic [wordsize-1:0] buf_data;
   logic                hit;

   assign hit         = buf_valid & (cpu_addr == buf_addr) & ~cpu_write_en;
   assign mem_req     = (state == S_BUSY);
   assign cpu_data_in = buf_data;
   assign cpu_stall   = reset & (((state == S_IDLE) & ~hit) | (state == S_BUSY));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         counter   <= '0;
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         bus_error <= 1'b0;
      end else begin
         bus_error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!hit) begin
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_data_out;
                  mem_we    <= cpu_write_en;
                  counter   <= '0;
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               counter <= counter + CW'(1);
               if (mem_ack) begin
                  // Writes refill the buffer with their own data to stay coherent.
                  buf_addr  <= mem_addr;
                  buf_data  <= mem_we ? mem_wdata : mem_rdata;
                  buf_valid <= 1'b1;
                  state     <= S_DONE;
               end else if ((timeout != 0) && (counter == TMO_LAST)) begin
                  bus_error <= 1'b1;
                  buf_valid <= 1'b0;
                  buf_data  <= '0;
                  state     <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         // Placed last so it overrides a same-cycle ack fill of buf_valid.
         if (invalidate) buf_valid <= 1'b0;
      end
   end

endmodule
